// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with DATA/STATUS/DIV/CTRL registers on the Bridge slave bus.
// Level interrupt on received byte available.
module uart_mmio #(
    parameter int unsigned DIV_RESET = 217,
    parameter int unsigned DIV_MIN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);
    localparam logic [15:0] DIV_RST   = 16'(DIV_RESET);
    localparam logic [15:0] DIV_FLOOR = 16'(DIV_MIN);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [1:0]  sel;
    logic        data_wr, status_wr, div_wr, ctrl_wr;
    logic [15:0] div_q, div_new;
    logic        rie;
    logic        rxv, ovr, ferr, txbusy;
    logic [7:0]  rx_byte;
    logic        unused_bits;

    assign sel       = Addr[3:2];
    assign data_wr   = (sel == 2'd0) && ByteEn[0];
    assign status_wr = (sel == 2'd1) && ByteEn[0];
    assign div_wr    = (sel == 2'd2) && (|ByteEn[1:0]);
    assign ctrl_wr   = (sel == 2'd3) && ByteEn[0];
    assign div_new   = {ByteEn[1] ? Din[15:8] : div_q[15:8],
                        ByteEn[0] ? Din[7:0]  : div_q[7:0]};
    assign unused_bits = ^{Addr[31:4], Addr[1:0], ByteEn[3:2], Din[31:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_RST;
            rie   <= 1'b0;
        end else begin
            if (div_wr) div_q <= (div_new < DIV_FLOOR) ? DIV_FLOOR : div_new;
            if (ctrl_wr) rie <= Din[0];
        end
    end

    // Transmitter
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic        tx_zero;

    assign tx_zero = (tx_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (data_wr) tx_next = TX_START;
            TX_START: if (tx_zero) tx_next = TX_DATA;
            TX_DATA:  if (tx_zero && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_zero) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        txbusy   = (tx_state != TX_IDLE);
        case (tx_state)
            TX_START: uart_txd = 1'b0;
            TX_DATA:  uart_txd = tx_shift[0];
            default:  uart_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_div   <= DIV_RST;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else if (tx_state == TX_IDLE) begin
            if (data_wr) begin
                tx_shift <= Din[7:0];
                tx_div   <= div_q;
                tx_cnt   <= div_q - 16'd1;
                tx_bit   <= '0;
            end
        end else if (tx_zero) begin
            tx_cnt <= tx_div - 16'd1;
            if (tx_state == TX_DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt - 16'd1;
        end
    end

    // Receiver
    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rxs;
    logic [15:0] rx_cnt, rx_div;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit;
    logic        rx_zero, stop_sample, rxv_clr;

    assign rx_zero     = (rx_cnt == '0);
    assign stop_sample = (rx_state == RX_STOP) && rx_zero;
    assign rxv_clr     = status_wr && Din[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_s1    <= uart_rxd;
            rxs      <= rx_s1;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_next = RX_START;
            RX_START: if (rx_zero) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_zero && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_zero) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_div   <= DIV_RST;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: if (!rxs) begin
                    rx_div <= div_q;
                    rx_cnt <= (div_q >> 1) - 16'd1;
                    rx_bit <= '0;
                end
                RX_DATA: if (rx_zero) begin
                    rx_shift <= {rxs, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                    rx_cnt   <= rx_div - 16'd1;
                end else begin
                    rx_cnt <= rx_cnt - 16'd1;
                end
                default: if (rx_zero) rx_cnt <= rx_div - 16'd1;
                         else         rx_cnt <= rx_cnt - 16'd1;
            endcase
        end
    end

    // Status set on the stop sample is ordered after the software clear so the set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte <= '0;
            rxv     <= 1'b0;
            ovr     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (rxv_clr) rxv <= 1'b0;
            if (status_wr && Din[2]) ovr  <= 1'b0;
            if (status_wr && Din[3]) ferr <= 1'b0;
            if (stop_sample) begin
                if (!rxs) begin
                    ferr <= 1'b1;
                end else if (!rxv || rxv_clr) begin
                    rx_byte <= rx_shift;
                    rxv     <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (sel)
            2'd0: Dout = {24'b0, rx_byte};
            2'd1: Dout = {28'b0, ferr, ovr, txbusy, rxv};
            2'd2: Dout = {16'b0, div_q};
            2'd3: Dout = {31'b0, rie};
            default: Dout = '0;
        endcase
    end

    assign irq = rie & rxv;
endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio: register access, TX waveform, RX status paths, loopback.
module tb_uart_mmio;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [3:0]  ByteEn;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        uart_rxd;
    logic        uart_txd;
    logic        irq;
    logic        rxd_drv;
    logic        loopback;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0;
    logic [9:0]  frame;

    assign uart_rxd = loopback ? uart_txd : rxd_drv;

    uart_mmio #(.DIV_RESET(217), .DIV_MIN(4)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .ByteEn(ByteEn), .Din(Din),
        .Dout(Dout), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        Addr = {28'b0, a, 2'b00};
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        Addr   = {28'b0, a, 2'b00};
        ByteEn = be;
        Din    = d;
        @(posedge clk);
        #1;
        ByteEn = '0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (8) @(posedge clk);
        end
        rxd_drv = stop;
        repeat (8) @(posedge clk);
        rxd_drv = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1; Addr = '0; ByteEn = '0; Din = '0;
        rxd_drv = 1'b1; loopback = 1'b0;
        idle(3);
        reset = 1'b0;

        rd(2'd0, "reset_data", 32'h0);
        rd(2'd1, "reset_status", 32'h0);
        rd(2'd2, "reset_div", 32'hD9);
        rd(2'd3, "reset_ctrl", 32'h0);
        check("reset_txd", {31'b0, uart_txd}, 32'h1);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // TX 0xA5 at 8 cycles/bit
        wr(2'd2, 4'b0011, 32'd8);
        rd(2'd2, "div8", 32'd8);
        frame = {1'b1, 8'hA5, 1'b0};
        wr(2'd0, 4'b0001, 32'hA5);
        t0 = cyc;
        rd(2'd1, "txbusy_set", 32'h2);
        for (int k = 0; k < 10; k++) begin
            wait_until(t0 + 8 * k);
            check($sformatf("tx_bit%0d_first", k), {31'b0, uart_txd}, {31'b0, frame[k]});
            if (k == 2) wr(2'd0, 4'b0001, 32'h00);
            wait_until(t0 + 8 * k + 7);
            check($sformatf("tx_bit%0d_last", k), {31'b0, uart_txd}, {31'b0, frame[k]});
        end
        wait_until(t0 + 79);
        rd(2'd1, "txbusy_end", 32'h2);
        wait_until(t0 + 80);
        rd(2'd1, "txbusy_clr", 32'h0);
        wait_until(t0 + 95);
        check("tx_dropped_write", {31'b0, uart_txd}, 32'h1);
        rd(2'd1, "tx_stays_idle", 32'h0);

        // RX 0x3C with interrupt enabled
        wr(2'd3, 4'b0001, 32'h1);
        send_frame(8'h3C, 1'b1);
        idle(5);
        rd(2'd1, "rx_status", 32'h1);
        rd(2'd0, "rx_data", 32'h3C);
        check("rx_irq_set", {31'b0, irq}, 32'h1);
        wr(2'd1, 4'b0001, 32'h1);
        rd(2'd1, "rxv_clear", 32'h0);
        check("rx_irq_clr", {31'b0, irq}, 32'h0);

        // Overrun
        send_frame(8'h11, 1'b1);
        idle(2);
        send_frame(8'h22, 1'b1);
        idle(5);
        rd(2'd0, "ovr_data", 32'h11);
        rd(2'd1, "ovr_status", 32'h5);
        wr(2'd1, 4'b0001, 32'h5);
        rd(2'd1, "ovr_clear", 32'h0);

        // Framing error
        send_frame(8'h55, 1'b0);
        idle(20);
        rd(2'd1, "ferr_status", 32'h8);
        rd(2'd0, "ferr_data", 32'h11);
        wr(2'd1, 4'b0001, 32'h8);
        rd(2'd1, "ferr_clear", 32'h0);

        // Short glitch rejected
        rxd_drv = 1'b0;
        idle(3);
        rxd_drv = 1'b1;
        idle(100);
        rd(2'd1, "glitch_status", 32'h0);
        rd(2'd0, "glitch_data", 32'h11);

        // Divisor clamp
        wr(2'd2, 4'b0011, 32'd2);
        rd(2'd2, "div_clamp", 32'd4);

        // Reset mid-frame
        wr(2'd2, 4'b0011, 32'd8);
        wr(2'd0, 4'b0001, 32'h00);
        idle(20);
        check("midframe_txd", {31'b0, uart_txd}, 32'h0);
        reset = 1'b1;
        idle(1);
        check("reset_abort_txd", {31'b0, uart_txd}, 32'h1);
        rd(2'd1, "reset_abort_status", 32'h0);
        reset = 1'b0;
        rd(2'd2, "reset_abort_div", 32'hD9);

        // Loopback
        wr(2'd2, 4'b0011, 32'd8);
        loopback = 1'b1;
        wr(2'd0, 4'b0001, 32'hFF);
        idle(100);
        rd(2'd0, "loop_ff_data", 32'hFF);
        rd(2'd1, "loop_ff_status", 32'h1);
        wr(2'd1, 4'b0001, 32'h1);
        wr(2'd0, 4'b0001, 32'h00);
        idle(100);
        rd(2'd0, "loop_00_data", 32'h00);
        rd(2'd1, "loop_00_status", 32'h1);
        check("loop_irq_off", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
